// File: rtl/train_sequencer.sv
// train_sequencer
//   Clocked training controller. On start it walks epoch_count training
//   epochs. Each epoch has four phases:
//     - weight load
//     - forward pass
//     - cost backprop
//     - weight update
//   For every beat it drives the weight storage, systolic array and input
//   loader strobes, together with the layer and row indices.
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   start, epoch_count     begin a run of epoch_count epochs (sampled in IDLE)
//   hold                   stall the current beat (strobes forced low)
//   abort                  return to IDLE on the next edge, no done pulse
//   busy, done             run in progress / one-cycle completion pulse
//   epoch_remaining        epochs left, including the current one
//   w_layer_index          layer addressed this beat
//   w_row_index            row addressed this beat
//   is_load, load_w        weight row read from storage / written into the array
//   i_is_load, use_z       fetch an input row / use the previous layer's z
//   backprop_cost          backprop a cost row
//   is_update              update weight storage by dc_dw
module train_sequencer #(
  parameter int SIZE        = 3,
  parameter int LAYER_COUNT = 2,
  parameter int EPOCH_W     = 16,
  parameter int IDX_W       = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [EPOCH_W-1:0] epoch_count,
  input  logic               hold,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [EPOCH_W-1:0] epoch_remaining,
  output logic [IDX_W-1:0]   w_layer_index,
  output logic [IDX_W-1:0]   w_row_index,
  output logic               is_load,
  output logic               load_w,
  output logic               i_is_load,
  output logic               use_z,
  output logic               backprop_cost,
  output logic               is_update
);

  typedef enum logic [2:0] {IDLE, LOAD, FWD, COST, UPDATE, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_ROW   = IDX_W'(SIZE - 1);
  localparam logic [IDX_W-1:0] LAST_LAYER = IDX_W'(LAYER_COUNT - 1);

  state_t             state;
  logic [IDX_W-1:0]   l;
  logic [IDX_W-1:0]   r;
  logic               row_last;
  logic [EPOCH_W-1:0] epoch_next;

  assign row_last   = (r == LAST_ROW);
  // The epoch count never wraps below zero.
  assign epoch_next = (epoch_remaining != '0) ? epoch_remaining - EPOCH_W'(1) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      l               <= '0;
      r               <= '0;
      epoch_remaining <= '0;
    end else if (abort) begin
      state           <= IDLE;
      l               <= '0;
      r               <= '0;
      epoch_remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            l <= '0;
            r <= '0;
            if (epoch_count != '0) begin
              epoch_remaining <= epoch_count;
              state           <= LOAD;
            end else begin
              state <= DONE;
            end
          end
        end
        // LOAD and FWD walk the layers in the same ascending order; only
        // their exit targets differ.
        LOAD, FWD: begin
          if (!hold) begin
            if (!row_last) begin
              r <= r + IDX_W'(1);
            end else begin
              r <= '0;
              if (l != LAST_LAYER) begin
                l <= l + IDX_W'(1);
              end else if (state == LOAD) begin
                l     <= '0;
                state <= FWD;
              end else begin
                l     <= LAST_LAYER;
                state <= COST;
              end
            end
          end
        end
        COST: begin
          if (!hold) begin
            if (!row_last) begin
              r <= r + IDX_W'(1);
            end else begin
              r     <= '0;
              l     <= LAST_LAYER;
              state <= UPDATE;
            end
          end
        end
        // UPDATE walks the layers from last to first.
        UPDATE: begin
          if (!hold) begin
            if (!row_last) begin
              r <= r + IDX_W'(1);
            end else begin
              r <= '0;
              if (l != '0) begin
                l <= l - IDX_W'(1);
              end else begin
                epoch_remaining <= epoch_next;
                l               <= '0;
                state           <= (epoch_next != '0) ? LOAD : DONE;
              end
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are decoded from the registered state and are suppressed while
  // the beat is held. The indices stay visible during a hold.
  assign busy          = (state != IDLE) && (state != DONE);
  assign done          = (state == DONE);
  assign w_layer_index = l;
  assign w_row_index   = r;
  assign is_load       = (state == LOAD) && !hold;
  assign load_w        = (state == LOAD) && !hold;
  assign i_is_load     = (state == FWD) && (l == '0) && !hold;
  assign use_z         = (((state == FWD) && (l != '0)) || (state == COST)) && !hold;
  assign backprop_cost = (state == COST) && !hold;
  assign is_update     = (state == UPDATE) && !hold;

endmodule

// File: tb/tb_train_sequencer.sv
module tb_train_sequencer;

  localparam int SIZE = 3;
  localparam int LC   = 2;
  localparam int EW   = 16;
  localparam int IW   = 8;

  // Strobe order: {is_load, load_w, i_is_load, use_z, backprop_cost, is_update}
  localparam logic [5:0] S_LOAD = 6'b110000;
  localparam logic [5:0] S_FWD0 = 6'b001000;
  localparam logic [5:0] S_FWDN = 6'b000100;
  localparam logic [5:0] S_COST = 6'b000110;
  localparam logic [5:0] S_UPD  = 6'b000001;

  typedef struct packed {
    logic [IW-1:0] l;
    logic [IW-1:0] r;
    logic [5:0]    s;
    logic [EW-1:0] er;
    logic          d;
  } obs_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [EW-1:0] epoch_count = '0;
  logic          hold = 1'b0;
  logic          abort = 1'b0;
  logic          busy, done;
  logic [EW-1:0] epoch_remaining;
  logic [IW-1:0] w_layer_index, w_row_index;
  logic          is_load, load_w, i_is_load, use_z, backprop_cost, is_update;
  logic [5:0]    strobes;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   busy_total = 0;
  int   b0;

  train_sequencer #(.SIZE(SIZE), .LAYER_COUNT(LC), .EPOCH_W(EW), .IDX_W(IW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .epoch_count(epoch_count),
    .hold(hold), .abort(abort), .busy(busy), .done(done),
    .epoch_remaining(epoch_remaining), .w_layer_index(w_layer_index),
    .w_row_index(w_row_index), .is_load(is_load), .load_w(load_w),
    .i_is_load(i_is_load), .use_z(use_z), .backprop_cost(backprop_cost),
    .is_update(is_update)
  );

  assign strobes = {is_load, load_w, i_is_load, use_z, backprop_cost, is_update};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(input int l, input int r, input logic [5:0] s, input int er, input logic d);
    obs_t o;
    o.l  = IW'(l);
    o.r  = IW'(r);
    o.s  = s;
    o.er = EW'(er);
    o.d  = d;
    exp_q.push_back(o);
  endtask

  task automatic push_load_fwd_cost(input int er);
    for (int l = 0; l < LC; l++)
      for (int r = 0; r < SIZE; r++) push(l, r, S_LOAD, er, 1'b0);
    for (int l = 0; l < LC; l++)
      for (int r = 0; r < SIZE; r++) push(l, r, (l == 0) ? S_FWD0 : S_FWDN, er, 1'b0);
    for (int r = 0; r < SIZE; r++) push(LC - 1, r, S_COST, er, 1'b0);
  endtask

  task automatic push_epoch(input int er);
    push_load_fwd_cost(er);
    for (int l = LC - 1; l >= 0; l--)
      for (int r = 0; r < SIZE; r++) push(l, r, S_UPD, er, 1'b0);
  endtask

  // Every beat with a strobe, and every done pulse, is matched against the queue.
  task automatic monitor();
    obs_t a, e;
    forever begin
      @(negedge clk);
      if (busy) busy_total++;
      if (done || strobes != 6'b0) begin
        a = '{l: w_layer_index, r: w_row_index, s: strobes, er: epoch_remaining, d: done};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output actual=%h required=none", a);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL beat actual l=%0d r=%0d s=%b er=%0d d=%b required l=%0d r=%0d s=%b er=%0d d=%b",
                     a.l, a.r, a.s, a.er, a.d, e.l, e.r, e.s, e.er, e.d);
          end
        end
      end
    end
  endtask

  task automatic kick(input int n);
    @(posedge clk);
    #1;
    start       = 1'b1;
    epoch_count = EW'(n);
    b0          = busy_total;
    @(posedge clk);
    #1;
    start       = 1'b0;
    epoch_count = '0;
  endtask

  task automatic wait_done(input string name, input int limit);
    bit got = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1;
        break;
      end
    end
    chk({name, "_done_seen"}, 32'(got), 32'd1);
    @(negedge clk);
    chk({name, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset state
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_strobes", 32'(strobes), 32'd0);
    chk("rst_idx", {16'd0, w_layer_index, w_row_index}, 32'd0);
    chk("rst_er", 32'(epoch_remaining), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Single epoch; a start while busy must be ignored
    push_epoch(1);
    push(0, 0, 6'b0, 0, 1'b1);
    kick(1);
    chk("e1_busy_first", 32'(busy), 32'd1);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; epoch_count = EW'(5);
    @(posedge clk);
    #1 start = 1'b0; epoch_count = '0;
    wait_done("e1", 100);
    chk("e1_busy_cycles", 32'(busy_total - b0), 32'd21);

    // Three epochs
    push_epoch(3);
    push_epoch(2);
    push_epoch(1);
    push(0, 0, 6'b0, 0, 1'b1);
    kick(3);
    wait_done("e3", 200);
    chk("e3_busy_cycles", 32'(busy_total - b0), 32'd63);

    // Hold for 4 cycles on FWD layer 1 row 1
    push_epoch(1);
    push(0, 0, 6'b0, 0, 1'b1);
    kick(1);
    begin
      bit seen = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (use_z && !backprop_cost && w_layer_index == 1 && w_row_index == 0) begin
          seen = 1;
          break;
        end
      end
      chk("hold_reach_fwd10", 32'(seen), 32'd1);
    end
    @(posedge clk);
    #1 hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("hold_strobes", 32'(strobes), 32'd0);
      chk("hold_idx", {16'd0, w_layer_index, w_row_index}, 32'h0101);
      chk("hold_busy", 32'(busy), 32'd1);
      @(posedge clk);
    end
    #1 hold = 1'b0;
    wait_done("hold", 100);
    chk("hold_busy_cycles", 32'(busy_total - b0), 32'd25);

    // Abort during UPDATE layer 0 with hold asserted
    push_load_fwd_cost(2);
    for (int r = 0; r < SIZE; r++) push(1, r, S_UPD, 2, 1'b0);
    push(0, 0, S_UPD, 2, 1'b0);
    kick(2);
    begin
      bit seen = 0;
      for (int i = 0; i < 60; i++) begin
        @(negedge clk);
        if (is_update && w_layer_index == 0) begin
          seen = 1;
          break;
        end
      end
      chk("abort_reach_upd0", 32'(seen), 32'd1);
    end
    @(posedge clk);
    #1 hold = 1'b1; abort = 1'b1;
    @(negedge clk);
    chk("abort_hold_strobes", 32'(strobes), 32'd0);
    chk("abort_hold_idx", {16'd0, w_layer_index, w_row_index}, 32'h0001);
    @(posedge clk);
    #1 hold = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_er", 32'(epoch_remaining), 32'd0);
    chk("abort_idx", {16'd0, w_layer_index, w_row_index}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("abort_no_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    chk("abort_queue_empty", 32'(exp_q.size()), 32'd0);

    // Zero epochs: done one cycle after start, busy never asserted
    push(0, 0, 6'b0, 0, 1'b1);
    kick(0);
    @(negedge clk);
    chk("zero_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("zero_done_one_cycle", 32'(done), 32'd0);
    chk("zero_busy_cycles", 32'(busy_total - b0), 32'd0);

    // Reset during FWD, then a clean epoch
    push_load_fwd_cost(1);
    for (int i = 0; i < 2 * SIZE + 2; i++) exp_q.pop_back();
    kick(1);
    begin
      bit seen = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (i_is_load && w_row_index == 0) begin
          seen = 1;
          break;
        end
      end
      chk("rstmid_reach_fwd", 32'(seen), 32'd1);
    end
    #1 reset_n = 1'b0;
    #1;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_strobes", 32'(strobes), 32'd0);
    chk("rstmid_idx", {16'd0, w_layer_index, w_row_index}, 32'd0);
    chk("rstmid_er", 32'(epoch_remaining), 32'd0);
    chk("rstmid_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    push_epoch(1);
    push(0, 0, 6'b0, 0, 1'b1);
    kick(1);
    wait_done("post_rst", 100);
    chk("post_rst_busy_cycles", 32'(busy_total - b0), 32'd21);

    repeat (3) @(negedge clk);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
